// File: rtl/regfile_wb_if.sv
// Write-back / decode side bus of the architectural register file.
// The pipeline drives it through the master modport; the register file is the slave.
interface regfile_wb_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic                  RegWrite;
   logic [ADDR_WIDTH-1:0] WriteRegister;
   logic [DATA_WIDTH-1:0] WriteData;
   logic [ADDR_WIDTH-1:0] ReadRegister1;
   logic [ADDR_WIDTH-1:0] ReadRegister2;
   logic [DATA_WIDTH-1:0] ReadData1;
   logic [DATA_WIDTH-1:0] ReadData2;

   modport master (
      output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2
   );

   modport slave (
      input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2
   );
endinterface

// File: rtl/regfile_wb.sv
// Architectural integer register file: one-hot decoded write port, two combinational
// read ports with same-cycle write bypass, and a storage-less hardwired-zero register.
module regfile_wb #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned ZERO_REG   = 31
) (
   input  logic         clk,
   input  logic         reset,
   regfile_wb_if.slave  bus
);
   localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
   localparam int unsigned HI_W     = ADDR_WIDTH - 3;
   localparam int unsigned NUM_HI   = 1 << HI_W;

   logic [NUM_HI-1:0]                     hi_dec;
   logic [7:0]                            lo_dec;
   logic [NUM_REGS-1:0]                   en_raw;
   logic [NUM_REGS-1:0]                   en;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   file_q;
   logic [DATA_WIDTH-1:0]                 rd1;
   logic [DATA_WIDTH-1:0]                 rd2;

   // Upper address bits select one 3:8 decoder bank; RegWrite gates the bank select.
   always_comb begin
      hi_dec = '0;
      if (bus.RegWrite)
         hi_dec[bus.WriteRegister[ADDR_WIDTH-1:3]] = 1'b1;
   end

   always_comb begin
      lo_dec = '0;
      lo_dec[bus.WriteRegister[2:0]] = 1'b1;
   end

   for (genvar g = 0; g < NUM_HI; g++) begin : g_bank
      assign en_raw[g*8 +: 8] = hi_dec[g] ? lo_dec : '0;
   end

   always_comb begin
      en           = en_raw;
      en[ZERO_REG] = 1'b0;
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == ZERO_REG) begin : g_zero
         assign file_q[i] = '0;
      end else begin : g_store
         logic [DATA_WIDTH-1:0] q;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               q <= '0;
            else if (en[i])
               q <= bus.WriteData;
         end

         assign file_q[i] = q;
      end
   end

   // en already folds in RegWrite, the address match and the zero-register exclusion,
   // so indexing it by the read address is exactly the bypass condition.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (reset) begin
         rd1 = en[bus.ReadRegister1] ? bus.WriteData : file_q[bus.ReadRegister1];
         rd2 = en[bus.ReadRegister2] ? bus.WriteData : file_q[bus.ReadRegister2];
      end
   end

   assign bus.ReadData1 = rd1;
   assign bus.ReadData2 = rd2;
endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb: reset, sweep, zero register,
// bypass, write disable, back-to-back writes and reset landing on a write edge.
module tb_regfile_wb;
   localparam int unsigned DW = 64;
   localparam int unsigned AW = 5;
   localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic [DW-1:0] model [32];

   regfile_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf_if ();

   regfile_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(31)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (rf_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) begin
         assert (!$isunknown(rf_if.RegWrite)) else begin
            failures++;
            $error("FAIL regwrite_x observed=%b required=0/1", rf_if.RegWrite);
         end
      end
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_pair(input int a, input int b, input string tag);
      rf_if.ReadRegister1 = 5'(a);
      rf_if.ReadRegister2 = 5'(b);
      #1;
      check({tag, "_p1"}, rf_if.ReadData1, model[a]);
      check({tag, "_p2"}, rf_if.ReadData2, model[b]);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      foreach (model[k]) model[k] = '0;

      // Reset held low: writes ignored, bypass suppressed, all reads 0.
      reset                = 1'b0;
      rf_if.RegWrite       = 1'b1;
      rf_if.WriteRegister  = 5'd5;
      rf_if.WriteData      = 64'h1234;
      rf_if.ReadRegister1  = '0;
      rf_if.ReadRegister2  = '0;
      for (int i = 0; i < 32; i++) read_pair(i, 31 - i, "reset_low");

      @(negedge clk);
      reset          = 1'b1;
      rf_if.RegWrite = 1'b0;
      read_pair(5, 5, "reset_write_ignored");

      // Asynchronous reset clears a written register without a clock edge.
      rf_if.RegWrite      = 1'b1;
      rf_if.WriteRegister = 5'd5;
      rf_if.WriteData     = 64'hDEAD_BEEF;
      tick();
      rf_if.RegWrite = 1'b0;
      model[5] = 64'hDEAD_BEEF;
      read_pair(5, 5, "x5_written");
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      model[5] = '0;
      read_pair(5, 5, "x5_async_clear");
      #1;
      reset = 1'b1;
      #1;
      read_pair(5, 5, "x5_after_release");

      // Write/read sweep.
      rf_if.RegWrite = 1'b1;
      for (int i = 0; i < 31; i++) begin
         rf_if.WriteRegister = 5'(i);
         rf_if.WriteData     = 64'(i) * STEP;
         model[i]            = 64'(i) * STEP;
         tick();
      end
      rf_if.RegWrite = 1'b0;
      for (int i = 0; i < 31; i++) read_pair(i, 30 - i, "sweep");
      read_pair(31, 31, "sweep_x31");

      // Zero register: write attempt ignored both before and after the edge.
      rf_if.RegWrite      = 1'b1;
      rf_if.WriteRegister = 5'd31;
      rf_if.WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
      read_pair(31, 31, "zero_inflight");
      tick();
      rf_if.RegWrite = 1'b0;
      read_pair(31, 31, "zero_after_edge");
      read_pair(30, 0, "zero_no_side_effect");

      // Bypass.
      rf_if.RegWrite      = 1'b1;
      rf_if.WriteRegister = 5'd7;
      rf_if.WriteData     = 64'h1111;
      tick();
      rf_if.RegWrite = 1'b0;
      model[7] = 64'h1111;
      rf_if.WriteData = 64'h2222;
      read_pair(7, 7, "bypass_off");
      rf_if.RegWrite = 1'b1;
      rf_if.ReadRegister1 = 5'd7;
      rf_if.ReadRegister2 = 5'd7;
      #1;
      check("bypass_p1", rf_if.ReadData1, 64'h2222);
      check("bypass_p2", rf_if.ReadData2, 64'h2222);
      rf_if.ReadRegister2 = 5'd8;
      #1;
      check("bypass_other_port", rf_if.ReadData2, 64'(8) * STEP);
      tick();
      rf_if.RegWrite = 1'b0;
      model[7] = 64'h2222;
      read_pair(7, 7, "bypass_committed");

      // Write disable: nothing changes.
      rf_if.RegWrite      = 1'b0;
      rf_if.WriteRegister = 5'd3;
      rf_if.WriteData     = 64'hABCD;
      tick();
      for (int i = 0; i < 32; i++) read_pair(i, 31 - i, "write_disable");

      // Back-to-back writes to one register: last edge wins.
      rf_if.RegWrite      = 1'b1;
      rf_if.WriteRegister = 5'd9;
      rf_if.WriteData     = 64'hAAAA;
      tick();
      rf_if.WriteData     = 64'hBBBB;
      tick();
      rf_if.RegWrite = 1'b0;
      model[9] = 64'hBBBB;
      read_pair(9, 10, "back_to_back");

      // Reset pulse straddling a write edge.
      rf_if.RegWrite      = 1'b1;
      rf_if.WriteRegister = 5'd12;
      rf_if.WriteData     = 64'h55;
      #7;
      reset = 1'b0;
      #4;
      reset = 1'b1;
      rf_if.RegWrite = 1'b0;
      foreach (model[k]) model[k] = '0;
      read_pair(12, 12, "midwrite_x12");
      read_pair(9, 7, "midwrite_others");

      // First edge after release accepts a write.
      rf_if.RegWrite      = 1'b1;
      rf_if.WriteRegister = 5'd12;
      rf_if.WriteData     = 64'h77;
      tick();
      rf_if.RegWrite = 1'b0;
      model[12] = 64'h77;
      read_pair(12, 13, "first_write_after_release");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
